data_memory_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the core's load/store unit (port 0) and the debug/program-loader port (port 1). Each port issues one word-addressed transaction at a time with a req/ack handshake. The arbiter picks a winner round-robin and drives the memory's address, write-data and write-enable for one access cycle. It then returns registered read data plus an out-of-range error flag to the winner.

---
 rtl/data_memory_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 24 ++
 rtl/data_memory_arbiter.sv | 99 +++++++++
 tb/tb_data_memory_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared FSM encoding and port ids for the data memory arbiter
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin picker
import data_memory_pkg::*;

module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    // On a tie the port that was not served last goes next.
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = PORT_DBG;
    end else begin
      grant_id = PORT_LSU;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - shares the single-port data memory between the LSU and debug ports
import data_memory_pkg::*;

module data_memory_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [WORDSIZE-1:0] addr0,
  input  logic [WORDSIZE-1:0] addr1,
  input  logic [WORDSIZE-1:0] wdata0,
  input  logic [WORDSIZE-1:0] wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic [WORDSIZE-1:0] rdata0,
  output logic [WORDSIZE-1:0] rdata1,
  output logic                err0,
  output logic                err1,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata,
  output logic                mem_write_en,
  input  logic [WORDSIZE-1:0] mem_rdata
);

  state_t state;
  logic   last_grant;
  logic   lat_we;
  logic   lat_id;
  logic   grant_valid;
  logic   grant_id;
  logic   in_range;
  logic [WORDSIZE-1:0] rd_val;

  rr_arbiter2 u_rr (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // mem_addr / mem_wdata are the latched request fields themselves.
  assign in_range     = (mem_addr < WORDSIZE'(SIZE));
  assign rd_val       = in_range ? mem_rdata : '0;
  assign mem_write_en = (state == ACCESS) && lat_we && in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_DBG;
      lat_we     <= 1'b0;
      lat_id     <= PORT_LSU;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            lat_we     <= (grant_id == PORT_DBG) ? we1 : we0;
            mem_addr   <= (grant_id == PORT_DBG) ? addr1 : addr0;
            mem_wdata  <= (grant_id == PORT_DBG) ? wdata1 : wdata0;
            lat_id     <= grant_id;
            last_grant <= grant_id;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // Capture happens on the same edge as the write, so writes return the old word.
          if (lat_id == PORT_LSU) begin
            rdata0 <= rd_val;
            err0   <= ~in_range;
            ack0   <= 1'b1;
          end else begin
            rdata1 <= rd_val;
            err1   <= ~in_range;
            ack1   <= 1'b1;
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [63:0] rdata0, rdata1;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write_en;

  logic [63:0] mem [0:511];
  logic [63:0] ref_mem [0:511];
  logic        tb_load = 1'b0;
  logic [8:0]  tb_load_addr = '0;
  logic [63:0] tb_load_data = '0;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.WORDSIZE(64), .SIZE(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (tb_load) mem[tb_load_addr] <= tb_load_data;
    else if (mem_write_en) mem[mem_addr[8:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_addr < 64'd512) ? mem[mem_addr[8:0]] : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic load(input int a, input logic [63:0] d);
    tb_load = 1'b1; tb_load_addr = a[8:0]; tb_load_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    tb_load = 1'b0;
  endtask

  task automatic set_port(input bit p, input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // Called at a negedge in IDLE; returns at the negedge where ack is seen.
  task automatic txn(input bit p, input bit w, input logic [63:0] a, input logic [63:0] d,
                     output logic [63:0] rd, output logic er, output int lat,
                     output int wen_cnt, output logic [63:0] wen_addr);
    lat = -1; wen_cnt = 0; wen_addr = '0; rd = '0; er = 1'b0;
    set_port(p, 1'b1, w, a, d);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_write_en) begin wen_cnt++; wen_addr = mem_addr; end
      if (p ? ack1 : ack0) begin
        lat = n; rd = p ? rdata1 : rdata0; er = p ? err1 : err0;
        break;
      end
    end
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_wen;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [63:0] rd, wa;
    logic        er;
    int          lat, wc;
    int          ack_port [4];
    int          ack_time [4];
    logic [63:0] ack_data [4];
    int          na, first, second;
    bit          pend [2];
    bit          pwe [2];
    logic [63:0] paddr [2];
    logic [63:0] pwd [2];
    int          age [2];
    logic [63:0] exp_rd;

    vecs[0] = '{0, 1, 64'd3,   64'hDEAD_BEEF, 64'd0,          1'b0, 1};
    vecs[1] = '{0, 0, 64'd3,   64'd0,         64'hDEAD_BEEF,  1'b0, 0};
    vecs[2] = '{1, 1, 64'd512, 64'h1234,      64'd0,          1'b1, 0};
    vecs[3] = '{1, 0, 64'd512, 64'd0,         64'd0,          1'b1, 0};
    vecs[4] = '{1, 0, 64'd3,   64'd0,         64'hDEAD_BEEF,  1'b0, 0};
    vecs[5] = '{1, 1, 64'd7,   64'd77,        64'd0,          1'b0, 1};
    vecs[6] = '{0, 0, 64'd7,   64'd0,         64'd77,         1'b0, 0};
    vecs[7] = '{0, 1, 64'd511, 64'hAA,        64'd0,          1'b0, 1};
    vecs[8] = '{0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,  1'b1, 0};
    vecs[9] = '{1, 0, 64'd511, 64'd0,         64'hAA,         1'b0, 0};

    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0;    wdata1 = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) load(i, (i < 2) ? 64'd5 : 64'd0);
    load(511, 64'd0);

    chk("rst_ack0", {63'd0, ack0}, 64'd0);
    chk("rst_ack1", {63'd0, ack1}, 64'd0);
    chk("rst_rdata0", rdata0, 64'd0);
    chk("rst_rdata1", rdata1, 64'd0);
    chk("rst_err", {62'd0, err0, err1}, 64'd0);
    chk("rst_wen", {63'd0, mem_write_en}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);

    rst_n = 1'b1;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ack0) begin lat = n; break; end
    end
    chk("rst_release_lat", 64'(lat), 64'd2);
    chk("rst_release_rdata0", rdata0, 64'd5);
    req0 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat, wc, wa);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_wen_cycles", i), 64'(wc), 64'(vecs[i].exp_wen));
      if (vecs[i].exp_wen == 1) chk($sformatf("vec%0d_wen_addr", i), wa, vecs[i].addr);
    end

    // Simultaneous requests held high: grants must alternate every 3 cycles.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 64'd0, '0);
    set_port(1, 1'b1, 1'b0, 64'd1, '0);
    na = 0;
    for (int n = 1; n <= 16 && na < 4; n++) begin
      @(negedge clk);
      if (ack0 && ack1) chk("tie_both_ack", 64'd1, 64'd0);
      if (ack0 || ack1) begin
        ack_port[na] = ack1 ? 1 : 0;
        ack_time[na] = n;
        ack_data[na] = ack1 ? rdata1 : rdata0;
        na++;
      end
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    chk("tie_ack_count", 64'(na), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < na) begin
        chk($sformatf("tie%0d_port", k), 64'(ack_port[k]), 64'(k % 2));
        chk($sformatf("tie%0d_time", k), 64'(ack_time[k]), 64'(2 + 3 * k));
        chk($sformatf("tie%0d_rdata", k), ack_data[k], 64'd5);
      end
    end

    // Back-to-back: req0 held through the cycle after ack.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 64'd3, '0);
    first = -1; second = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ack0) begin
        if (first < 0) first = n;
        else begin second = n; break; end
      end
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    chk("b2b_first", 64'(first), 64'd2);
    chk("b2b_second", 64'(second), 64'd5);
    chk("b2b_rdata", rdata0, 64'hDEAD_BEEF);

    // Reset during ACCESS of a write to addr 7.
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 64'd7, 64'd999);
    @(negedge clk);
    chk("rstmid_wen_before", {63'd0, mem_write_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_wen_after", {63'd0, mem_write_en}, 64'd0);
    @(negedge clk);
    chk("rstmid_ack", {62'd0, ack0, ack1}, 64'd0);
    chk("rstmid_rdata0", rdata0, 64'd0);
    chk("rstmid_mem_addr", mem_addr, 64'd0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rstmid_ack2", {62'd0, ack0, ack1}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 64'd7, '0, rd, er, lat, wc, wa);
    chk("rstmid_readback", rd, 64'd77);

    // Randomized traffic against a transaction-level memory model.
    @(negedge clk);
    for (int i = 0; i < 16; i++) load(i, {$urandom, $urandom});
    pend[0] = 0; pend[1] = 0; age[0] = 0; age[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (ack0 && ack1) chk("rand_both_ack", 64'd1, 64'd0);
      for (int p = 0; p < 2; p++) begin
        logic ak;
        ak = p ? ack1 : ack0;
        if (ak) begin
          if (!pend[p]) chk($sformatf("rand_spurious_ack%0d", p), 64'd1, 64'd0);
          else begin
            exp_rd = (paddr[p] < 64'd512) ? ref_mem[paddr[p][8:0]] : 64'd0;
            chk($sformatf("rand_rdata%0d", p), p ? rdata1 : rdata0, exp_rd);
            chk($sformatf("rand_err%0d", p), {63'd0, p ? err1 : err0},
                {63'd0, paddr[p] >= 64'd512});
            if (pwe[p] && paddr[p] < 64'd512) ref_mem[paddr[p][8:0]] = pwd[p];
            pend[p] = 0;
            set_port(p[0], 1'b0, 1'b0, '0, '0);
          end
        end else if (pend[p]) begin
          age[p]++;
          if (age[p] > 12) begin
            chk($sformatf("rand_timeout%0d", p), 64'(age[p]), 64'd12);
            pend[p] = 0;
            set_port(p[0], 1'b0, 1'b0, '0, '0);
          end
        end else if (cyc < 2950 && $urandom_range(0, 1) == 1) begin
          pend[p] = 1; age[p] = 0;
          pwe[p] = $urandom_range(0, 1) == 1;
          paddr[p] = ($urandom_range(0, 7) == 0) ? 64'(512 + $urandom_range(0, 100))
                                                  : 64'($urandom_range(0, 15));
          pwd[p] = {$urandom, $urandom};
          set_port(p[0], 1'b1, pwe[p], paddr[p], pwd[p]);
        end
      end
    end
    chk("rand_drained", {62'd0, pend[0], pend[1]}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
